// File: rtl/ysyx_25050148_pkg.sv
// ysyx_25050148_pkg
//   Shared definitions for the fetch/decode front end.
//   - RISC-V opcodes of the control-flow instructions (JAL, JALR, BRANCH)
//   - reset PC of the core
//   - the buffered fetch entry {pc, inst, cf} at the core's native 32-bit width
//   - is_cf(): opcode classifier shared by the instruction buffer and the IDU
package ysyx_25050148_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [XLEN-1:0] RESET_PC = 32'h80000000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            cf;
  } ibuf_entry_t;

  // True for any instruction that can redirect the fetch stream.
  function automatic logic is_cf(input logic [6:0] opcode);
    return (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/ysyx_25050148_cf_detect.sv
// ysyx_25050148_cf_detect
//   Combinational control-flow classifier.
//   Ports:
//     opcode  in  7   instruction bits [6:0]
//     cf      out 1   1 for JAL, JALR or BRANCH
module ysyx_25050148_cf_detect
  import ysyx_25050148_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       cf
);

  assign cf = is_cf(opcode);

endmodule

// File: rtl/ysyx_25050148_ibuf.sv
// ysyx_25050148_ibuf
//   Fetch-to-decode instruction buffer: a DEPTH-entry circular FIFO of
//   {pc, inst, cf} between the IFU and the IDU, with show-ahead output and a
//   single-cycle flush for redirects.
//
//   Handshake: a transfer happens on a rising clk edge when valid && ready are
//   both high on that side (push = in_valid && in_ready, pop = out_valid &&
//   out_ready). in_ready and out_valid depend only on registered occupancy, so
//   neither depends combinationally on the other side's inputs. A push with
//   in_ready=0 or a pop with out_valid=0 is simply ignored.
//
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     in_valid/in_ready   IFU side handshake
//     in_pc, in_inst      fetched PC and instruction word
//     out_valid/out_ready IDU side handshake
//     out_pc, out_inst    head entry (read straight from storage)
//     out_cf              head entry is JAL/JALR/BRANCH (classified at push)
//     flush               drop all entries; wins over push and pop
//     count               current occupancy, 0..DEPTH
//
//   Optional build macro YSYX_25050148_IBUF_PERF_EN adds
//     perf_stall_cnt      cycles with in_valid && !in_ready
//     perf_flush_cnt      total entries discarded by flushes
//   and reports both at end of simulation.
//
//   DEPTH must be a power of two and at least 2.
module ysyx_25050148_ibuf
  import ysyx_25050148_pkg::*;
#(
  parameter int ADDR_WIDTH = XLEN,
  parameter int DATA_WIDTH = XLEN,
  parameter int DEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      in_pc,
  input  logic [DATA_WIDTH-1:0]      in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_WIDTH-1:0]      out_pc,
  output logic [DATA_WIDTH-1:0]      out_inst,
  output logic                       out_cf,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
`ifdef YSYX_25050148_IBUF_PERF_EN
  ,
  output logic [31:0]                perf_stall_cnt,
  output logic [31:0]                perf_flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
    logic                  cf;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;

  logic push;
  logic pop;
  logic in_cf;

  // --------------------------------------------------------------------------
  // Classification happens once, on the way in.
  // --------------------------------------------------------------------------
  ysyx_25050148_cf_detect u_cf_detect (
    .opcode (in_inst[6:0]),
    .cf     (in_cf)
  );

  // --------------------------------------------------------------------------
  // Flow control, all derived from registered occupancy.
  // --------------------------------------------------------------------------
  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Show-ahead: head is always visible; stale when empty.
  assign out_pc   = mem[rd_ptr].pc;
  assign out_inst = mem[rd_ptr].inst;
  assign out_cf   = mem[rd_ptr].cf;

  // --------------------------------------------------------------------------
  // Occupancy update (flush handled in the register process).
  // --------------------------------------------------------------------------
  always_comb begin
    count_nxt = count_q;
    unique case ({push, pop})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pointers and occupancy. Pointers are PTR_W bits so they wrap by overflow;
  // count disambiguates full from empty.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Storage. Cleared only by reset; a flush leaves contents in place since
  // the pointers alone decide what is live.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !flush) begin
      mem[wr_ptr] <= '{pc: in_pc, inst: in_inst, cf: in_cf};
    end
  end

`ifdef YSYX_25050148_IBUF_PERF_EN
  // --------------------------------------------------------------------------
  // Performance counters, both wrapping modulo 2^32.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      // Occupancy at the flush edge is exactly the number of dropped entries.
      if (flush) perf_flush_cnt <= perf_flush_cnt + 32'(count_q);
    end
  end

`ifndef SYNTHESIS
  final $display("ibuf perf: stall_cnt=%0d flush_cnt=%0d", perf_stall_cnt, perf_flush_cnt);
`endif
`endif

endmodule

// File: tb/tb_ysyx_25050148_ibuf.sv
module tb_ysyx_25050148_ibuf;

  localparam int DEPTH = 2;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_cf;
  logic        flush = 1'b0;
  logic [1:0]  count;

  always #5 clk = ~clk;

  ysyx_25050148_ibuf #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_cf    (out_cf),
    .flush     (flush),
    .count     (count)
  );

  // --------------------------------------------------------------------------
  // Scoreboard counters and helpers
  // --------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Reference classification straight from the ISA opcode list.
  function automatic logic ref_cf(input logic [31:0] inst);
    logic [6:0] op;
    op = inst[6:0];
    return (op == 7'h6f) || (op == 7'h67) || (op == 7'h63);
  endfunction

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [1:0]  ecnt;
    logic        eir;
    logic [31:0] epc;
    logic        ecf;
  } vec_t;

  vec_t vecs[8];

  // Behavioural model for the random phase: a plain queue of entries.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        cf;
  } ent_t;

  ent_t model_q[$];
  logic [31:0] exp_q[$];   // expected pop order of PCs
  logic [6:0]  ops[5];

  initial begin
    // Vectors, starting from an empty, freshly reset buffer.
    //            iv  pc            inst          ordy fl | ev ecnt eir epc          ecf
    vecs[0] = '{1'b1, 32'h80000000, 32'h00000297, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h80000000, 1'b0};
    vecs[1] = '{1'b1, 32'h80000004, 32'h0000006f, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h80000000, 1'b0};
    vecs[2] = '{1'b1, 32'h80000008, 32'h00000013, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 32'h80000004, 1'b1};
    vecs[3] = '{1'b0, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 32'h00000000, 1'b0};
    vecs[4] = '{1'b1, 32'h8000000c, 32'h00000063, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h8000000c, 1'b1};
    vecs[5] = '{1'b1, 32'h80000010, 32'h00008067, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h8000000c, 1'b1};
    vecs[6] = '{1'b1, 32'h80000020, 32'h00000013, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h00000000, 1'b0};
    vecs[7] = '{1'b1, 32'h80000014, 32'h00000013, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h80000014, 1'b0};

    ops[0] = 7'h6f; ops[1] = 7'h67; ops[2] = 7'h63; ops[3] = 7'h13; ops[4] = 7'h33;

    // ---- reset state ----
    rst = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_out_pc",    64'(out_pc),    64'd0);
    chk("rst_out_inst",  64'(out_inst),  64'd0);
    chk("rst_out_cf",    64'(out_cf),    64'd0);
    rst = 1'b0;
    step();

    // ---- directed table ----
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].ordy, vecs[i].fl);
      step();
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].ev));
      chk($sformatf("vec%0d_count", i), 64'(count),     64'(vecs[i].ecnt));
      chk($sformatf("vec%0d_ready", i), 64'(in_ready),  64'(vecs[i].eir));
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_pc", i), 64'(out_pc), 64'(vecs[i].epc));
        chk($sformatf("vec%0d_cf", i), 64'(out_cf), 64'(vecs[i].ecf));
      end
    end

    // ---- simultaneous push/pop at count=1; head becomes the new entry ----
    for (int i = 1; i <= 8; i++) begin
      logic [31:0] pc;
      pc = 32'h80000014 + 32'(4 * i);
      drive(1'b1, pc, 32'h00000013, 1'b1, 1'b0);
      step();
      chk($sformatf("pp%0d_count", i), 64'(count),  64'd1);
      chk($sformatf("pp%0d_pc", i),    64'(out_pc), 64'(pc));
    end

    // ---- fill to 2 then reset asynchronously mid-cycle ----
    drive(1'b1, 32'h80000100, 32'h0000006f, 1'b0, 1'b0);
    step();
    chk("prerst_count", 64'(count), 64'd2);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    chk("arst_count",     64'(count),     64'd0);
    step();
    rst = 1'b0;
    step();
    chk("postrst_out_pc", 64'(out_pc), 64'd0);
    chk("postrst_out_cf", 64'(out_cf), 64'd0);

    // ---- randomized run against the queue model ----
    for (int c = 0; c < 500; c++) begin
      logic        iv, ordy, fl;
      logic [31:0] r, pc, inst;
      int          sz;
      iv   = 1'($urandom_range(0, 3) != 0);
      ordy = 1'($urandom_range(0, 2) != 0);
      fl   = 1'($urandom_range(0, 15) == 0);
      r    = $urandom();
      pc   = {r[31:2], 2'b00};
      r    = $urandom();
      inst = {r[31:7], ops[$urandom_range(0, 4)]};
      drive(iv, pc, inst, ordy, fl);
      sz = model_q.size();
      step();
      if (fl) begin
        model_q.delete();
        exp_q.delete();
      end else begin
        if (ordy && sz > 0) begin
          void'(model_q.pop_front());
          void'(exp_q.pop_front());
        end
        if (iv && sz < DEPTH) begin
          model_q.push_back('{pc: pc, inst: inst, cf: ref_cf(inst)});
          exp_q.push_back(pc);
        end
      end
      chk("rnd_count", 64'(count),     64'(model_q.size()));
      chk("rnd_valid", 64'(out_valid), 64'(model_q.size() != 0));
      chk("rnd_ready", 64'(in_ready),  64'(model_q.size() < DEPTH));
      if (model_q.size() != 0) begin
        chk("rnd_pc",   64'(out_pc),   64'(exp_q[0]));
        chk("rnd_inst", 64'(out_inst), 64'(model_q[0].inst));
        chk("rnd_cf",   64'(out_cf),   64'(model_q[0].cf));
      end
    end

    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
